// File: rtl/pop_ctrl_pkg.sv
// Shared constants and types for the POP mode controller: LED encodings,
// controller state, and the default configuration of the standard four-mode set.
package pop_ctrl_pkg;

  localparam logic [1:0] LED_OFF  = 2'd0;
  localparam logic [1:0] LED_ON   = 2'd1;
  localparam logic [1:0] LED_SLOW = 2'd2;
  localparam logic [1:0] LED_FAST = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    GUARD = 1'b1
  } ctrl_state_t;

  // Modes: 0 setup, 1 POP cycle, 2 dark, 3 pump calibration.
  localparam logic [15:0] POP_PASS_MASK = 16'h00F0;
  localparam logic [15:0] POP_FORCE_VAL = 16'h800A;
  localparam logic [7:0]  POP_LED_CFG   = {LED_SLOW, LED_ON, LED_FAST, LED_OFF};

  function automatic logic led_sel(input logic [1:0] cfg, input logic slow, input logic fast);
    logic led;
    case (cfg)
      LED_OFF:  led = 1'b0;
      LED_ON:   led = 1'b1;
      LED_SLOW: led = slow;
      default:  led = fast;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, tick-gated debounce counter and a
// one-cycle press event that only fires after the button has been seen released.
module button_debouncer #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic btn_n,
  output logic press_event
);

  logic       btn_meta;
  logic       btn_sync;
  logic [7:0] cnt;
  logic       deb_pressed;
  logic       armed;

  logic       disagree;
  logic       flip;
  logic       deb_nxt;
  logic       arm_set;

  assign disagree = sample_tick && (!btn_sync != deb_pressed);
  assign flip     = disagree && ((cnt + 8'd1) == 8'(DEBOUNCE_TICKS));
  assign deb_nxt  = flip ? !deb_pressed : deb_pressed;
  // Arming needs a tick that actually sees the button up, so a button held
  // through reset cannot generate a press until it is let go.
  assign arm_set  = sample_tick && !deb_nxt && btn_sync;

  assign press_event = flip && !deb_pressed && armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta    <= 1'b1;
      btn_sync    <= 1'b1;
      cnt         <= 8'd0;
      deb_pressed <= 1'b0;
      armed       <= 1'b0;
    end else begin
      btn_meta    <= btn_n;
      btn_sync    <= btn_meta;
      if (sample_tick) begin
        cnt <= (disagree && !flip) ? cnt + 8'd1 : 8'd0;
      end
      deb_pressed <= deb_nxt;
      armed       <= armed || arm_set;
    end
  end

endmodule

// File: rtl/pop_mode_controller.sv
// Mode selector and channel mux for the POP timing top level. A debounced button
// steps the mode; every mode change is bracketed by a guard interval at SAFE_VAL.
module pop_mode_controller
  import pop_ctrl_pkg::*;
#(
  parameter int NUM_MODES      = 4,
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int GUARD_CYCLES   = 250,
  parameter logic [NUM_MODES*NUM_CH-1:0] PASS_MASK = POP_PASS_MASK,
  parameter logic [NUM_MODES*NUM_CH-1:0] FORCE_VAL = POP_FORCE_VAL,
  parameter logic [2*NUM_MODES-1:0]      LED_CFG   = POP_LED_CFG,
  parameter logic [NUM_CH-1:0]           SAFE_VAL  = '0,
  localparam int MODE_W = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              mode_btn_n,
  input  logic              slow_pulse,
  input  logic              fast_pulse,
  input  logic [NUM_CH-1:0] timer_in,
  output logic [NUM_CH-1:0] ch_out,
  output logic              led_out,
  output logic [MODE_W-1:0] mode,
  output logic              guard_active
);

  localparam int GUARD_W = $clog2(GUARD_CYCLES + 2);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);
  localparam ctrl_state_t RESET_STATE = (GUARD_CYCLES == 0) ? RUN : GUARD;

  if (NUM_MODES < 2 || NUM_MODES > 16 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255) begin : g_bad_params
    $error("pop_mode_controller: NUM_MODES must be 2..16 and DEBOUNCE_TICKS 1..255");
  end

  logic press_event;

  button_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .btn_n       (mode_btn_n),
    .press_event (press_event)
  );

  ctrl_state_t       state, state_nxt;
  logic [MODE_W-1:0] mode_q, mode_nxt;
  logic [GUARD_W-1:0] gcnt, gcnt_nxt;
  logic [NUM_CH-1:0] ch_nxt;
  logic              led_nxt;
  logic [NUM_CH-1:0] pass_row;
  logic [NUM_CH-1:0] force_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      mode_q  <= '0;
      gcnt    <= GUARD_INIT;
      ch_out  <= SAFE_VAL;
      led_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      gcnt    <= gcnt_nxt;
      ch_out  <= ch_nxt;
      led_out <= led_nxt;
    end
  end

  // Presses arriving while the guard runs are dropped, not queued.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    gcnt_nxt  = gcnt;
    case (state)
      RUN: begin
        if (press_event) begin
          mode_nxt = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
          if (GUARD_CYCLES != 0) begin
            state_nxt = GUARD;
            gcnt_nxt  = GUARD_INIT;
          end
        end
      end
      GUARD: begin
        gcnt_nxt = gcnt - GUARD_W'(1);
        if (gcnt <= GUARD_W'(1)) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Outputs are computed from the next state so the first safe level lands on
  // the same edge that accepts the press.
  always_comb begin
    pass_row  = PASS_MASK[int'(mode_nxt) * NUM_CH +: NUM_CH];
    force_row = FORCE_VAL[int'(mode_nxt) * NUM_CH +: NUM_CH];
    ch_nxt    = SAFE_VAL;
    led_nxt   = 1'b0;
    if (state_nxt == RUN) begin
      ch_nxt  = (pass_row & timer_in) | (~pass_row & force_row);
      led_nxt = led_sel(LED_CFG[2 * int'(mode_nxt) +: 2], slow_pulse, fast_pulse);
    end
  end

  assign guard_active = (state == GUARD);
  assign mode         = mode_q;

endmodule
